fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage that produces the instruction word consumed by the decode controller, and acts on the controller's Branch/Jump outputs.
- Holds the PC and issues single-outstanding requests to instruction memory over a req/ready + rvalid handshake.
- Buffers one returned word while decode is stalled, and drives the IF/ID pipeline register (Instruction, PCPlus4, InstrValid).
- Applies branch/jump redirects with flush of wrong-path fetches.

Parameters:
RESET_PC  32'h0000_0000  PC value loaded on reset
NOP_INSTR  32'h0000_0000  word driven on Instruction when the IF/ID register holds a bubble

Ports:
Clk  input  1  rising-edge clock
Rst_n  input  1  asynchronous reset, active-low
IMemReq  output  1  fetch request valid
IMemAddr  output  32  fetch address; equals PC
IMemReady  input  1  memory accepts the request this cycle
IMemRvalid  input  1  read data valid
IMemRdata  input  32  returned instruction word
Branch  input  1  decode-stage branch (controller output)
BranchTaken  input  1  branch condition result from compare logic
BranchTarget  input  32  branch target address
Jump  input  1  decode-stage jump, J/JAL/JR (controller output)
JumpTarget  input  32  jump target, register value for JR
Stall  input  1  hazard unit: hold IF/ID and PC
PC  output  32  current fetch PC
Instruction  output  32  IF/ID instruction to decode
PCPlus4  output  32  IF/ID fetch address + 4, for branch base and the JAL link
InstrValid  output  1  IF/ID holds a real instruction
AlignErr  output  1  one-cycle pulse: redirect target had [1:0] != 0

Behaviour:
- Reset (Rst_n low, asynchronous):
  - PC=RESET_PC, state=FETCH, Discard=0, buffer empty.
  - Instruction=NOP_INSTR, PCPlus4=0, InstrValid=0, AlignErr=0.
  - IMemReq is forced to 0 while Rst_n is low.
- Redirect = Jump | (Branch & BranchTaken).
  - Target = JumpTarget if Jump, else BranchTarget. Jump wins if both are asserted.
  - PC <= {Target[31:2],2'b00}. AlignErr <= (Target[1:0]!=0) for one cycle.
  - IF/ID is flushed: Instruction<=NOP_INSTR, InstrValid<=0.
  - Redirect has priority over Stall.
- States:
  - FETCH:
    - IMemReq=1, IMemAddr=PC.
    - IMemReady=1 -> WAIT, and the fetch address is latched as ReqPC.
    - Redirect before acceptance: PC updates and IMemReq stays high with the new address next cycle. Address changes are allowed while not accepted.
  - WAIT:
    - IMemReq=0, wait for IMemRvalid.
    - Redirect in WAIT sets Discard=1.
    - Rvalid with Discard=1 (or with a same-cycle redirect): word dropped, Discard<=0, -> FETCH.
    - Rvalid, no redirect, Stall=0: IF/ID <= {IMemRdata, ReqPC+4, valid=1}, PC<=ReqPC+4, -> FETCH.
    - Rvalid, no redirect, Stall=1: word and ReqPC captured into the buffer, -> FULL.
  - FULL:
    - IMemReq=0.
    - Stall=0 and no redirect: buffer -> IF/ID, PC<=BufPC+4, buffer cleared, -> FETCH.
    - Redirect: buffer cleared, -> FETCH at target.
- IF/ID update rules:
  - Stall=1 with no redirect: IF/ID holds its value.
  - Stall=0 and no word delivered this cycle: InstrValid<=0 (bubble), Instruction<=NOP_INSTR.
- Latency: minimum 3 cycles from IMemReq to InstrValid.
  - Accept in cycle 0, rvalid in cycle 1, IF/ID loaded at the edge closing cycle 1, so InstrValid is visible in cycle 2 (3 cycles counting the request cycle).
  - Throughput is one instruction per 2 cycles with a zero-wait memory. Single outstanding request only.
- Arithmetic: +4 is 32-bit modulo; 32'hFFFF_FFFC+4 = 32'h0000_0000.
- Rdata arriving when not in WAIT is ignored.

Test Plan:
- Reset: Rst_n low mid-WAIT -> IMemReq=0, PC=0, InstrValid=0 immediately. After release, IMemReq=1 with IMemAddr=0.
- Sequential fetch, zero-wait memory returning 0x20080005 @0 and 0x20090003 @4 -> Instruction=0x20080005 with PCPlus4=4, then 0x20090003 with PCPlus4=8, one every 2 cycles.
- Stall=1 for 3 cycles while rvalid returns word @8 -> IF/ID holds its previous value, state FULL, no new IMemReq. Stall drops -> word @8 loaded with PCPlus4=0xC, next request to 0xC.
- Redirect while WAIT (Jump=1, JumpTarget=0x40) -> returned word discarded, InstrValid=0, next IMemAddr=0x40.
- Branch=1, BranchTaken=0 -> no redirect, sequential flow continues. Branch=1, BranchTaken=1, BranchTarget=0x102 -> PC=0x100, AlignErr pulses 1 cycle.
- Simultaneous Jump and Stall in FULL -> buffer cleared, IF/ID flushed, fetch issued at JumpTarget. PC=0xFFFFFFFC fetch -> PCPlus4=0, next IMemAddr=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding requests to
// instruction memory, buffers one returned word across a decode stall, drives
// the IF/ID register and applies branch/jump redirects with wrong-path flush.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic        IMemRvalid,
    input  logic [31:0] IMemRdata,
    input  logic        Branch,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        Stall,
    output logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic [31:0] PCPlus4,
    output logic        InstrValid,
    output logic        AlignErr
);

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_WAIT,
        ST_FULL
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] req_pc, req_pc_n;
    logic        discard, discard_n;
    logic [31:0] buf_word, buf_word_n;
    logic [31:0] buf_pc, buf_pc_n;
    logic [31:0] if_instr, if_instr_n;
    logic [31:0] if_pcplus4, if_pcplus4_n;
    logic        if_valid, if_valid_n;
    logic        align_err, align_err_n;

    logic        redirect;
    logic [31:0] target;
    logic        deliver;
    logic [31:0] deliver_word;
    logic [31:0] deliver_pc;
    logic [31:0] deliver_next;

    // Jump has priority over a taken branch when both fire together.
    assign redirect = Jump | (Branch & BranchTaken);
    assign target   = Jump ? JumpTarget : BranchTarget;

    assign IMemReq     = (state == ST_FETCH) && Rst_n;
    assign IMemAddr    = pc;
    assign PC          = pc;
    assign Instruction = if_instr;
    assign PCPlus4     = if_pcplus4;
    assign InstrValid  = if_valid;
    assign AlignErr    = align_err;

    // Next-state, PC, buffer and IF/ID selection.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        req_pc_n     = req_pc;
        discard_n    = discard;
        buf_word_n   = buf_word;
        buf_pc_n     = buf_pc;
        if_instr_n   = if_instr;
        if_pcplus4_n = if_pcplus4;
        if_valid_n   = if_valid;
        align_err_n  = 1'b0;
        deliver      = 1'b0;
        deliver_word = '0;
        deliver_pc   = '0;

        case (state)
            ST_FETCH: begin
                if (IMemReady) begin
                    state_n   = ST_WAIT;
                    req_pc_n  = pc;
                    // A redirect in the accepting cycle makes this fetch wrong-path.
                    discard_n = redirect;
                end
            end
            ST_WAIT: begin
                if (IMemRvalid) begin
                    state_n   = ST_FETCH;
                    discard_n = 1'b0;
                    if (discard || redirect) begin
                        state_n = ST_FETCH;
                    end else if (!Stall) begin
                        deliver      = 1'b1;
                        deliver_word = IMemRdata;
                        deliver_pc   = req_pc;
                    end else begin
                        buf_word_n = IMemRdata;
                        buf_pc_n   = req_pc;
                        state_n    = ST_FULL;
                    end
                end else if (redirect) begin
                    discard_n = 1'b1;
                end
            end
            ST_FULL: begin
                if (redirect) begin
                    state_n = ST_FETCH;
                end else if (!Stall) begin
                    deliver      = 1'b1;
                    deliver_word = buf_word;
                    deliver_pc   = buf_pc;
                    state_n      = ST_FETCH;
                end
            end
            default: state_n = ST_FETCH;
        endcase

        deliver_next = deliver_pc + 32'd4;
        if (deliver) begin
            pc_n = deliver_next;
        end

        if (redirect) begin
            pc_n        = {target[31:2], 2'b00};
            align_err_n = |target[1:0];
            if_instr_n  = NOP_INSTR;
            if_valid_n  = 1'b0;
        end else if (deliver) begin
            if_instr_n   = deliver_word;
            if_pcplus4_n = deliver_next;
            if_valid_n   = 1'b1;
        end else if (!Stall) begin
            if_instr_n = NOP_INSTR;
            if_valid_n = 1'b0;
        end
    end

    // State, PC, buffer and IF/ID registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            req_pc     <= '0;
            discard    <= 1'b0;
            buf_word   <= '0;
            buf_pc     <= '0;
            if_instr   <= NOP_INSTR;
            if_pcplus4 <= '0;
            if_valid   <= 1'b0;
            align_err  <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            req_pc     <= req_pc_n;
            discard    <= discard_n;
            buf_word   <= buf_word_n;
            buf_pc     <= buf_pc_n;
            if_instr   <= if_instr_n;
            if_pcplus4 <= if_pcplus4_n;
            if_valid   <= if_valid_n;
            align_err  <= align_err_n;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized stall/redirect/memory
// timing, checked against a program-order model (next expected fetch PC and a
// fixed memory image).
module tb_fetch_unit;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic        IMemRvalid;
    logic [31:0] IMemRdata;
    logic        Branch;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        Stall;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic [31:0] PCPlus4;
    logic        InstrValid;
    logic        AlignErr;

    localparam logic [31:0] NOP = 32'h0000_0000;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .IMemReq     (IMemReq),
        .IMemAddr    (IMemAddr),
        .IMemReady   (IMemReady),
        .IMemRvalid  (IMemRvalid),
        .IMemRdata   (IMemRdata),
        .Branch      (Branch),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .Jump        (Jump),
        .JumpTarget  (JumpTarget),
        .Stall       (Stall),
        .PC          (PC),
        .Instruction (Instruction),
        .PCPlus4     (PCPlus4),
        .InstrValid  (InstrValid),
        .AlignErr    (AlignErr)
    );

    always #5 Clk = ~Clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Program-order model and memory responder state.
    logic [31:0] exp_pc;
    logic        outstanding;
    int unsigned resp_delay;
    logic [31:0] resp_addr;
    int unsigned idle;
    int unsigned dmin, dmax, ready_pct;
    logic        stray_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        if (a == 32'h4) return 32'h2009_0003;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rand_target();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        return 32'($urandom_range(0, 511));
    endfunction

    task automatic model_reset();
        exp_pc      = 32'h0;
        outstanding = 1'b0;
        resp_delay  = 0;
        resp_addr   = 32'h0;
        idle        = 0;
        IMemRvalid  = 1'b0;
    endtask

    // One clock: check pre-edge outputs, advance, check post-edge outputs, drive memory.
    task automatic tick();
        logic        acc, redir, rv_now;
        logic [31:0] tgt, addr_pre, l_instr, l_p4;
        logic        l_valid;
        acc      = IMemReq && IMemReady;
        redir    = Jump || (Branch && BranchTaken);
        tgt      = Jump ? JumpTarget : BranchTarget;
        rv_now   = IMemRvalid && outstanding;
        addr_pre = IMemAddr;
        l_instr  = Instruction;
        l_p4     = PCPlus4;
        l_valid  = InstrValid;
        if (outstanding) check("single_outstanding", {31'b0, IMemReq}, 32'h0);
        if (IMemReq) check("fetch_addr", IMemAddr, exp_pc);

        @(posedge Clk);
        @(negedge Clk);

        check("align_err", {31'b0, AlignErr}, {31'b0, redir && (tgt[1:0] != 2'b00)});
        if (redir) begin
            check("flush_valid", {31'b0, InstrValid}, 32'h0);
            exp_pc = {tgt[31:2], 2'b00};
            idle   = 0;
        end else if (Stall) begin
            check("hold_instr", Instruction, l_instr);
            check("hold_pcplus4", PCPlus4, l_p4);
            check("hold_valid", {31'b0, InstrValid}, {31'b0, l_valid});
        end else if (InstrValid) begin
            check("deliver_instr", Instruction, memword(exp_pc));
            check("deliver_pcplus4", PCPlus4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            idle   = 0;
        end
        if (!InstrValid) check("bubble_nop", Instruction, NOP);
        idle++;
        if (idle > 64) begin
            check("progress_timeout", idle, 64);
            idle = 0;
        end

        if (rv_now) outstanding = 1'b0;
        if (acc) begin
            outstanding = 1'b1;
            resp_addr   = addr_pre;
            resp_delay  = $urandom_range(dmax, dmin);
        end

        IMemRvalid = 1'b0;
        IMemRdata  = $urandom;
        if (outstanding) begin
            if (resp_delay == 0) begin
                IMemRvalid = 1'b1;
                IMemRdata  = memword(resp_addr);
            end else begin
                resp_delay--;
            end
        end else if (stray_en && $urandom_range(0, 7) == 0) begin
            IMemRvalid = 1'b1;
        end
        IMemReady = ($urandom_range(0, 99) < ready_pct);
    endtask

    initial begin
        Rst_n = 1'b0;
        IMemReady = 1'b1; IMemRvalid = 1'b0; IMemRdata = '0;
        Branch = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
        Jump = 1'b0; JumpTarget = '0; Stall = 1'b0;
        dmin = 0; dmax = 0; ready_pct = 100; stray_en = 1'b0;
        model_reset();

        #12;
        check("rst_req", {31'b0, IMemReq}, 32'h0);
        check("rst_pc", PC, 32'h0);
        check("rst_valid", {31'b0, InstrValid}, 32'h0);
        check("rst_instr", Instruction, NOP);
        check("rst_pcplus4", PCPlus4, 32'h0);
        check("rst_align", {31'b0, AlignErr}, 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        check("post_rst_req", {31'b0, IMemReq}, 32'h1);
        check("post_rst_addr", IMemAddr, 32'h0);

        // Sequential fetch with zero-wait memory: one word every two cycles.
        tick();
        tick();
        check("seq0_valid", {31'b0, InstrValid}, 32'h1);
        check("seq0_instr", Instruction, 32'h2008_0005);
        check("seq0_pcplus4", PCPlus4, 32'h4);
        tick();
        check("seq_gap_valid", {31'b0, InstrValid}, 32'h0);
        tick();
        check("seq1_instr", Instruction, 32'h2009_0003);
        check("seq1_pcplus4", PCPlus4, 32'h8);

        // Stall across the return of word @8.
        Stall = 1'b1;
        tick(); tick(); tick();
        check("stall_req", {31'b0, IMemReq}, 32'h0);
        check("stall_hold_instr", Instruction, 32'h2009_0003);
        Stall = 1'b0;
        tick();
        check("unstall_instr", Instruction, memword(32'h8));
        check("unstall_pcplus4", PCPlus4, 32'hC);
        check("unstall_addr", IMemAddr, 32'hC);
        check("unstall_req", {31'b0, IMemReq}, 32'h1);

        // Jump while waiting: returned word discarded.
        dmin = 1; dmax = 1;
        tick();
        Jump = 1'b1; JumpTarget = 32'h40;
        tick();
        check("jwait_valid", {31'b0, InstrValid}, 32'h0);
        check("jwait_pc", PC, 32'h40);
        Jump = 1'b0; dmin = 0; dmax = 0;
        tick();
        check("jwait_valid2", {31'b0, InstrValid}, 32'h0);
        check("jwait_addr", IMemAddr, 32'h40);
        check("jwait_req", {31'b0, IMemReq}, 32'h1);

        // Branch not taken, then taken to a misaligned target.
        Branch = 1'b1; BranchTaken = 1'b0; BranchTarget = 32'h200;
        tick(); tick();
        check("bnt_pcplus4", PCPlus4, 32'h44);
        check("bnt_addr", IMemAddr, 32'h44);
        BranchTaken = 1'b1; BranchTarget = 32'h102;
        tick();
        check("bt_pc", PC, 32'h100);
        check("bt_align", {31'b0, AlignErr}, 32'h1);
        Branch = 1'b0; BranchTaken = 1'b0;
        tick();
        check("bt_align_pulse", {31'b0, AlignErr}, 32'h0);
        check("bt_addr", IMemAddr, 32'h100);

        // Jump with stall while the buffer is full, to the top of memory.
        Stall = 1'b1;
        tick(); tick();
        Jump = 1'b1; JumpTarget = 32'hFFFF_FFFC;
        tick();
        check("jfull_valid", {31'b0, InstrValid}, 32'h0);
        check("jfull_instr", Instruction, NOP);
        check("jfull_addr", IMemAddr, 32'hFFFF_FFFC);
        check("jfull_req", {31'b0, IMemReq}, 32'h1);
        Jump = 1'b0; Stall = 1'b0;
        tick(); tick();
        check("wrap_pcplus4", PCPlus4, 32'h0);
        check("wrap_instr", Instruction, memword(32'hFFFF_FFFC));
        check("wrap_addr", IMemAddr, 32'h0);

        // Randomized stalls, redirects and memory timing.
        dmin = 0; dmax = 2; ready_pct = 70; stray_en = 1'b1;
        for (int n = 0; n < 600; n++) begin
            int unsigned r;
            r = $urandom_range(0, 19);
            Branch       = (r <= 2) || (r == 5);
            BranchTaken  = (r == 5) || ($urandom_range(0, 1) == 1);
            Jump         = (r == 3) || (r == 4) || (r == 5);
            BranchTarget = rand_target();
            JumpTarget   = rand_target();
            Stall        = ($urandom_range(0, 9) < 3);
            tick();
        end

        // Asynchronous reset while a fetch is outstanding.
        Branch = 1'b0; BranchTaken = 1'b0; Jump = 1'b0; Stall = 1'b0;
        dmin = 3; dmax = 3; ready_pct = 100; stray_en = 1'b0;
        JumpTarget = 32'h0000_0124;
        Jump = 1'b1;
        tick();
        Jump = 1'b0;
        for (int n = 0; n < 20 && !outstanding; n++) tick();
        check("reach_wait", {31'b0, outstanding}, 32'h1);
        #2 Rst_n = 1'b0;
        #1;
        check("arst_req", {31'b0, IMemReq}, 32'h0);
        check("arst_pc", PC, 32'h0);
        check("arst_valid", {31'b0, InstrValid}, 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        model_reset();
        #1;
        check("arst_rel_req", {31'b0, IMemReq}, 32'h1);
        check("arst_rel_addr", IMemAddr, 32'h0);
        dmin = 0; dmax = 0;
        for (int n = 0; n < 8; n++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
